// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory arbiter:
//   - state_t        : arbiter FSM states (IDLE, FETCH, LOAD, ACK)
//   - BEATS          : byte beats per 32-bit word transfer
//   - ADDR_W_DEFAULT : default byte-address width of the instruction memory
//   - word_byte      : extract byte lane k of a 32-bit little-endian word
//   - word_set_byte  : replace byte lane k of a 32-bit little-endian word
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int BEATS          = 4;

    // Requester indices into the two-bit request/grant vectors
    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        ACK   = 2'd3
    } state_t;

    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] word_set_byte(input logic [31:0] word,
                                                  input logic [1:0]  idx,
                                                  input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. When both requesters are active the one
// that was not granted most recently wins. After reset requester 0 (fetch)
// is favoured.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   req     : request vector, bit 0 = fetch, bit 1 = load
//   update  : commit the current grant into the last-grant history
//   gnt     : one-hot (or zero) combinational grant
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 1 means requester 1 held the last grant, so requester 0 wins a tie
    logic last_q;
    logic last_d;

    // Grant selection from current requests and last-grant history
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant history update, only when a grant is actually taken
    always_comb begin
        last_d = last_q;
        if (update && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; reset leaves fetch favoured
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Arbitrates a CPU fetch port and a program-loader write port onto a single
// external byte-wide, single-port instruction memory. Each granted request
// moves one 32-bit little-endian word as four consecutive byte beats, then
// acknowledges the granted requester with a one-cycle pulse.
// Ports:
//   clk, reset_n         : rising-edge clock, synchronous active-low reset
//   f_req, f_addr        : fetch request / byte address (held until f_ack)
//   f_ack, f_rdata       : fetch done pulse / assembled fetch word
//   l_req, l_addr        : loader request / byte address (held until l_ack)
//   l_wdata, l_ack       : loader word / write-done pulse
//   m_addr, m_we         : memory byte address / write enable
//   m_wdata, m_rdata     : memory write byte / combinational read byte
//   busy                 : high whenever the FSM is not in IDLE
// Memory-side outputs are registered one cycle ahead of their beat, so the
// value driven during beat k is computed while the FSM sits in the previous
// cycle (the grant cycle for beat 0).
// ---------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ack,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    output logic              busy
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t              state_q,   state_d;
    logic [1:0]          beat_q,    beat_d;
    logic [ADDR_W-1:0]   base_q,    base_d;
    logic [31:0]         f_rdata_q, f_rdata_d;
    logic                f_ack_q,   f_ack_d;
    logic                l_ack_q,   l_ack_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic                m_we_q,    m_we_d;
    logic [7:0]          m_wdata_q, m_wdata_d;
    logic                busy_q,    busy_d;

    logic [1:0]          req_s;
    logic [1:0]          gnt_s;
    logic                arb_update_s;
    logic [1:0]          beat_nxt_s;
    logic                addr_unused_s;

    // Upper address bits are outside the memory and deliberately ignored
    assign addr_unused_s = ^{f_addr[31:ADDR_W], l_addr[31:ADDR_W]};

    assign req_s[REQ_FETCH] = f_req;
    assign req_s[REQ_LOAD]  = l_req;
    assign beat_nxt_s       = beat_q + 2'd1;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .update  (arb_update_s),
        .gnt     (gnt_s)
    );

    // FSM next state, beat sequencing and next-cycle memory/ack outputs
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        f_rdata_d    = f_rdata_q;
        f_ack_d      = 1'b0;
        l_ack_d      = 1'b0;
        m_addr_d     = '0;
        m_we_d       = 1'b0;
        m_wdata_d    = 8'h00;
        arb_update_s = 1'b0;

        case (state_q)
            IDLE: begin
                beat_d = 2'd0;
                if (gnt_s[REQ_FETCH]) begin
                    state_d      = FETCH;
                    base_d       = f_addr[ADDR_W-1:0];
                    m_addr_d     = f_addr[ADDR_W-1:0];
                    arb_update_s = 1'b1;
                end else if (gnt_s[REQ_LOAD]) begin
                    state_d      = LOAD;
                    base_d       = l_addr[ADDR_W-1:0];
                    m_addr_d     = l_addr[ADDR_W-1:0];
                    m_we_d       = 1'b1;
                    m_wdata_d    = word_byte(l_wdata, 2'd0);
                    arb_update_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            FETCH: begin
                // m_rdata belongs to the address driven in this beat
                f_rdata_d = word_set_byte(f_rdata_q, beat_q, m_rdata);
                if (beat_q == LAST_BEAT) begin
                    state_d = ACK;
                    beat_d  = 2'd0;
                    f_ack_d = 1'b1;
                end else begin
                    beat_d   = beat_nxt_s;
                    // Sum truncates to ADDR_W, giving the wrap past the top
                    m_addr_d = base_q + ADDR_W'(beat_nxt_s);
                end
            end

            LOAD: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ACK;
                    beat_d  = 2'd0;
                    l_ack_d = 1'b1;
                end else begin
                    beat_d    = beat_nxt_s;
                    m_addr_d  = base_q + ADDR_W'(beat_nxt_s);
                    m_we_d    = 1'b1;
                    m_wdata_d = word_byte(l_wdata, beat_nxt_s);
                end
            end

            ACK: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end

            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            base_q    <= '0;
            f_rdata_q <= 32'h0000_0000;
            f_ack_q   <= 1'b0;
            l_ack_q   <= 1'b0;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            f_rdata_q <= f_rdata_d;
            f_ack_q   <= f_ack_d;
            l_ack_q   <= l_ack_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
        end
    end

    // Write enable is masked by reset so the beat in flight when reset is
    // asserted is not committed to memory at the reset edge.
    assign m_we    = m_we_q & reset_n;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign f_ack   = f_ack_q;
    assign l_ack   = l_ack_q;
    assign f_rdata = f_rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a 256-byte memory model attached to
// the memory port. A backdoor write port preloads memory contents.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        l_req;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_ack;
    logic [7:0]  m_addr;
    logic        m_we;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        busy;

    logic [7:0]  mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [7:0]  bd_data;

    int vectors;
    int miscompares;

    imem_arbiter #(.ADDR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_ack   (f_ack),
        .f_rdata (f_rdata),
        .l_req   (l_req),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_ack   (l_ack),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External byte memory: combinational read, synchronous write
    assign m_rdata = mem[m_addr];
    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr] <= m_wdata;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    // Called in an IDLE cycle; leaves the bench in the following IDLE cycle
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
        logic [7:0] ea;
        f_req  = 1'b1;
        f_addr = addr;
        for (int k = 0; k < 4; k++) begin
            tick();
            ea = addr[7:0] + 8'(k);
            chk("fetch_m_addr", 32'(m_addr), 32'(ea));
            chk("fetch_m_we", 32'(m_we), 32'h0);
            chk("fetch_busy", 32'(busy), 32'h1);
        end
        tick();
        chk("fetch_f_ack", 32'(f_ack), 32'h1);
        chk("fetch_l_ack", 32'(l_ack), 32'h0);
        chk("fetch_f_rdata", f_rdata, exp);
        chk("fetch_ack_m_addr", 32'(m_addr), 32'h0);
        f_req = 1'b0;
        tick();
        chk("fetch_f_ack_drop", 32'(f_ack), 32'h0);
        chk("fetch_idle_busy", 32'(busy), 32'h0);
        chk("fetch_hold_rdata", f_rdata, exp);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] ea;
        logic [31:0] eb;
        l_req   = 1'b1;
        l_addr  = addr;
        l_wdata = data;
        for (int k = 0; k < 4; k++) begin
            tick();
            ea = addr[7:0] + 8'(k);
            eb = (data >> (8 * k)) & 32'h0000_00FF;
            chk("load_m_addr", 32'(m_addr), 32'(ea));
            chk("load_m_we", 32'(m_we), 32'h1);
            chk("load_m_wdata", 32'(m_wdata), eb);
        end
        tick();
        chk("load_l_ack", 32'(l_ack), 32'h1);
        chk("load_f_ack", 32'(f_ack), 32'h0);
        chk("load_ack_m_we", 32'(m_we), 32'h0);
        l_req = 1'b0;
        tick();
        chk("load_l_ack_drop", 32'(l_ack), 32'h0);
        chk("load_idle_busy", 32'(busy), 32'h0);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        f_req   = 1'b0;
        f_addr  = 32'h0;
        l_req   = 1'b0;
        l_addr  = 32'h0;
        l_wdata = 32'h0;
        bd_we   = 1'b0;
        bd_addr = 8'h00;
        bd_data = 8'h00;

        // Preload memory while the DUT is held in reset
        tick();
        poke(8'h00, 8'h04); poke(8'h01, 8'h10); poke(8'h02, 8'h11); poke(8'h03, 8'hE4);
        for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 8'h00);
        for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 8'h55);
        poke(8'hFE, 8'h00); poke(8'hFF, 8'h00);

        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_f_ack", 32'(f_ack), 32'h0);
        chk("rst_l_ack", 32'(l_ack), 32'h0);
        chk("rst_m_we", 32'(m_we), 32'h0);
        chk("rst_m_addr", 32'(m_addr), 32'h0);
        chk("rst_m_wdata", 32'(m_wdata), 32'h0);
        chk("rst_f_rdata", f_rdata, 32'h0);

        // Fetch only from address 0
        reset_n = 1'b1;
        do_fetch(32'h0000_0000, 32'hE411_1004);

        // Load at 0x20 (upper address bits set, must be ignored), then fetch it
        do_load(32'hDEAD_BE20, 32'hE081_0002);
        chk("load20_mem", mem_word(8'h20), 32'hE081_0002);
        do_fetch(32'h0000_0020, 32'hE081_0002);

        // Load wrapping past the top of memory
        do_load(32'h0000_00FE, 32'hAABB_CCDD);
        chk("wrap_mem_fe", 32'(mem[8'hFE]), 32'h0000_00DD);
        chk("wrap_mem_ff", 32'(mem[8'hFF]), 32'h0000_00CC);
        chk("wrap_mem_00", 32'(mem[8'h00]), 32'h0000_00BB);
        chk("wrap_mem_01", 32'(mem[8'h01]), 32'h0000_00AA);

        // Contention from reset: F, L, F, L with both requests held
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        f_req   = 1'b1;
        f_addr  = 32'h0000_0000;
        l_req   = 1'b1;
        l_addr  = 32'h0000_0060;
        l_wdata = 32'h1234_5678;
        for (int t = 0; t < 4; t++) begin
            repeat (5) tick();
            chk("rr_f_ack", 32'(f_ack), (t % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_l_ack", 32'(l_ack), (t % 2 == 0) ? 32'h0 : 32'h1);
            if (t == 0) chk("rr_f_rdata", f_rdata, 32'hE411_AABB);
            if (t == 3) begin
                f_req = 1'b0;
                l_req = 1'b0;
            end
            tick();
            chk("rr_idle_busy", 32'(busy), 32'h0);
        end
        chk("rr_mem60", mem_word(8'h60), 32'h1234_5678);

        // Reset during beat 2 of a load
        l_req   = 1'b1;
        l_addr  = 32'h0000_0040;
        l_wdata = 32'h3322_1100;
        repeat (3) tick();
        chk("midrst_beat2_we", 32'(m_we), 32'h1);
        chk("midrst_beat2_addr", 32'(m_addr), 32'h0000_0042);
        reset_n = 1'b0;
        l_req   = 1'b0;
        tick();
        chk("midrst_m_we", 32'(m_we), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_l_ack", 32'(l_ack), 32'h0);
        chk("midrst_m_addr", 32'(m_addr), 32'h0);
        chk("midrst_f_rdata", f_rdata, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_no_ack", 32'(l_ack), 32'h0);
        end
        chk("midrst_mem", mem_word(8'h40), 32'h5555_1100);

        // Load request rising during fetch beat 1
        f_req  = 1'b1;
        f_addr = 32'h0000_0020;
        tick();
        tick();
        chk("late_beat1_addr", 32'(m_addr), 32'h0000_0021);
        l_req   = 1'b1;
        l_addr  = 32'h0000_0080;
        l_wdata = 32'h0BAD_F00D;
        for (int k = 2; k < 4; k++) begin
            tick();
            chk("late_fetch_addr", 32'(m_addr), 32'h20 + 32'(k));
            chk("late_fetch_we", 32'(m_we), 32'h0);
        end
        tick();
        chk("late_f_ack", 32'(f_ack), 32'h1);
        chk("late_l_ack0", 32'(l_ack), 32'h0);
        chk("late_f_rdata", f_rdata, 32'hE081_0002);
        f_req = 1'b0;
        tick();
        chk("late_idle_busy", 32'(busy), 32'h0);
        tick();
        chk("late_load_we", 32'(m_we), 32'h1);
        chk("late_load_addr", 32'(m_addr), 32'h0000_0080);
        chk("late_load_wdata", 32'(m_wdata), 32'h0000_000D);
        repeat (4) tick();
        chk("late_l_ack", 32'(l_ack), 32'h1);
        chk("late_rdata_hold", f_rdata, 32'hE081_0002);
        l_req = 1'b0;
        tick();
        chk("late_mem80", mem_word(8'h80), 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, which is the byte-address width of the instruction memory (256 bytes).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port f_req, input, 1 bit: CPU fetch request, held high until f_ack.
REQ-005 The block SHALL have port f_addr, input, 32 bits: fetch byte address, held stable while f_req is high.
REQ-006 The block SHALL have port f_ack, output, 1 bit: one-cycle pulse; f_rdata is valid in this cycle.
REQ-007 The block SHALL have port f_rdata, output, 32 bits: assembled little-endian fetch word.
REQ-008 The block SHALL have port l_req, input, 1 bit: program-loader write request, held high until l_ack.
REQ-009 The block SHALL have port l_addr, input, 32 bits: loader byte address, held stable while l_req is high.
REQ-010 The block SHALL have port l_wdata, input, 32 bits: loader word, written little-endian.
REQ-011 The block SHALL have port l_ack, output, 1 bit: one-cycle pulse marking write completion.
REQ-012 The block SHALL have port m_addr, output, ADDR_W bits: byte address to the single-port byte memory.
REQ-013 The block SHALL have port m_we, output, 1 bit: byte write enable.
REQ-014 The block SHALL have port m_wdata, output, 8 bits: write byte.
REQ-015 The block SHALL have port m_rdata, input, 8 bits: read byte, combinational from m_addr in the same cycle.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FETCH, LOAD and ACK.
REQ-018 In IDLE, with exactly one request high, the block SHALL grant that requester and latch base = addr[ADDR_W-1:0].
REQ-019 In IDLE, with both requests high, the block SHALL grant round-robin: the requester not granted last wins; after reset, fetch wins.
REQ-020 On grant the FSM SHALL enter FETCH or LOAD with beat counter 0 and SHALL run beats 0..3 on four consecutive cycles.
REQ-021 During beat k, m_addr SHALL equal (base + k) mod 2^ADDR_W; wrap-around past the top of memory is legal; misaligned bases are legal.
REQ-022 In FETCH beat k, m_rdata SHALL be captured into f_rdata[8k+7:8k], and m_we SHALL be 0.
REQ-023 In LOAD beat k, m_we SHALL be 1 and m_wdata SHALL equal l_wdata[8k+7:8k].
REQ-024 After beat 3 the FSM SHALL enter ACK, pulse f_ack or l_ack (the granted one only) for one cycle, then return to IDLE.
REQ-025 Latency SHALL be: request seen in IDLE at cycle N, beats at N+1..N+4, ack at N+5, IDLE again at N+6.
REQ-026 f_rdata SHALL hold its value from ACK until beat 0 of the next fetch.
REQ-027 A request that rises while another transaction is in progress SHALL wait and SHALL be evaluated in the next IDLE cycle; it SHALL never be dropped.
REQ-028 m_addr SHALL be 0 and m_we SHALL be 0 in IDLE and ACK.
REQ-029 Address bits above ADDR_W-1 SHALL be ignored.

Reset
REQ-030 While reset_n is low at a rising edge, the FSM SHALL go to IDLE, the beat counter to 0, and the round-robin pointer to favour fetch.
REQ-031 While reset_n is low at a rising edge, f_ack, l_ack, m_we, busy, m_addr, m_wdata and f_rdata SHALL all go to 0.
REQ-032 A reset mid-transaction SHALL abort it with no ack; bytes already written stay in memory; m_we SHALL be 0 from the cycle after the reset edge.

Structure
REQ-033 Package imem_pkg SHALL hold the state enum (IDLE, FETCH, LOAD, ACK), the constant BEATS = 4, and the default ADDR_W.
REQ-034 The two-requester round-robin grant SHALL be the one sub-module, rr_arb2, with inputs req[1:0] and update, output gnt[1:0], and an internal last-grant flop.
REQ-035 The memory array SHALL be outside this block.

Verification
REQ-036 Fetch only: memory bytes 0..3 = 04,10,11,E4; f_req with f_addr=0 -> f_ack 5 cycles after grant, f_rdata=E4111004, m_we never 1.
REQ-037 Load then fetch: l_req with l_addr=0x20 and l_wdata=E0810002 -> bytes 0x20..0x23 = 02,00,81,E0 and l_ack pulses once; a following fetch from 0x20 returns E0810002.
REQ-038 Contention: f_req and l_req both rise in the same cycle after reset -> fetch is served first, then load; with both held high continuously, grants alternate F,L,F,L.
REQ-039 Wrap: load at l_addr=0xFE with l_wdata=AABBCCDD -> writes 0xFE=DD, 0xFF=CC, 0x00=BB, 0x01=AA.
REQ-040 Reset mid-load: reset_n low during beat 2 -> no l_ack, m_we=0 next cycle, busy=0, bytes for beats 0..1 are written and beats 2..3 are unchanged.
REQ-041 Late request: l_req rises during a fetch beat 1 -> fetch completes undisturbed, and the load is granted in the IDLE cycle after the f_ack.
